apb_master: RTL and testbench

Single-outstanding-transfer AMBA APB master bridging a simple local request interface (`newd`/`Addr`/`datain`/`wr`) onto an APB bus with 4-bit address and 8-bit data. It sits between a local controller and one APB slave, runs the IDLE → SETUP → ACCESS protocol, and returns read data on `dataout`. An optional watchdog aborts stalled transfers and flags them on `Pslverr`.

---
 rtl/apb_master.sv | 157 +++++++++++++++
 tb/tb_apb_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master that bridges a local request interface
// (newd/Addr/datain/wr) onto a 4-bit address / 8-bit data APB bus.
//
// Ports:
//   Pclk     - clock, rising edge
//   Presetn  - asynchronous reset, active-HIGH despite the name
//   Addr     - request address         datain - request write data
//   wr       - request direction (1 = write)
//   newd     - request valid (level)
//   PRdata   - APB read data           Pready - APB slave ready
//   Psel     - APB select              Penable - APB enable
//   Pslverr  - master-generated abort flag (watchdog timeout)
//   Paddr    - APB address             PWdata - APB write data
//   Pwrite   - APB direction           dataout - last completed read data
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to enable the ACCESS-phase
// watchdog (parameter TIMEOUT, default 15). Without it ACCESS waits forever and
// Pslverr is tied low.
module apb_master #(
`ifdef APB_MASTER_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 15,
`endif
  localparam int unsigned AW = 4,
  localparam int unsigned DW = 8
) (
  input  logic          Pclk,
  input  logic          Presetn,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] datain,
  input  logic          wr,
  input  logic          newd,
  input  logic [DW-1:0] PRdata,
  input  logic          Pready,
  output logic          Psel,
  output logic          Penable,
  output logic          Pslverr,
  output logic [AW-1:0] Paddr,
  output logic [DW-1:0] PWdata,
  output logic          Pwrite,
  output logic [DW-1:0] dataout
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state_q, state_d;
  logic            psel_d, penable_d, pwrite_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d, dataout_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            pslverr_d;
`endif

  // Next-state and next-output logic; outputs are the registered copies of *_d.
  always_comb begin
    state_d   = state_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    paddr_d   = Paddr;
    pwdata_d  = PWdata;
    pwrite_d  = Pwrite;
    dataout_d = dataout;
`ifdef APB_MASTER_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    pslverr_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (newd) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = Addr;
          pwdata_d = datain;
          pwrite_d = wr;
`ifdef APB_MASTER_TIMEOUT_EN
          wcnt_d   = '0;
`endif
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (Pready) begin
          if (!Pwrite) dataout_d = PRdata;
          // Back-to-back: a pending request skips IDLE and goes straight to SETUP.
          if (newd) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = Addr;
            pwdata_d = datain;
            pwrite_d = wr;
`ifdef APB_MASTER_TIMEOUT_EN
            wcnt_d   = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          // Abort on the TIMEOUT-th consecutive not-ready edge.
          if (wcnt_q == CW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            pslverr_d = 1'b1;
          end else begin
            wcnt_d    = wcnt_q + CW'(1);
            psel_d    = 1'b1;
            penable_d = 1'b1;
          end
`else
          psel_d    = 1'b1;
          penable_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Pclk or posedge Presetn) begin
    if (Presetn) begin
      state_q <= IDLE;
      Psel    <= 1'b0;
      Penable <= 1'b0;
      Paddr   <= '0;
      PWdata  <= '0;
      Pwrite  <= 1'b0;
      dataout <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wcnt_q  <= '0;
      Pslverr <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      Psel    <= psel_d;
      Penable <= penable_d;
      Paddr   <= paddr_d;
      PWdata  <= pwdata_d;
      Pwrite  <= pwrite_d;
      dataout <= dataout_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      Pslverr <= pslverr_d;
`endif
    end
  end

`ifndef APB_MASTER_TIMEOUT_EN
  assign Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master. Table-driven single
// transfers plus hand-written back-to-back, watchdog and mid-transfer reset
// sequences; expected results are queued when a request is issued and popped
// when the transfer completes.
module tb_apb_master;

  logic       Pclk = 1'b0;
  logic       Presetn = 1'b1;
  logic [3:0] Addr = '0;
  logic [7:0] datain = '0;
  logic       wr = 1'b0;
  logic       newd = 1'b0;
  logic [7:0] PRdata = '0;
  logic       Pready = 1'b0;
  logic       Psel, Penable, Pslverr, Pwrite;
  logic [3:0] Paddr;
  logic [7:0] PWdata, dataout;

  apb_master dut (
    .Pclk    (Pclk),
    .Presetn (Presetn),
    .Addr    (Addr),
    .datain  (datain),
    .wr      (wr),
    .newd    (newd),
    .PRdata  (PRdata),
    .Pready  (Pready),
    .Psel    (Psel),
    .Penable (Penable),
    .Pslverr (Pslverr),
    .Paddr   (Paddr),
    .PWdata  (PWdata),
    .Pwrite  (Pwrite),
    .dataout (dataout)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       wr;
    logic [7:0] prdata;
    int         waits;
  } vec_t;

  typedef struct {
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic       pwrite;
    logic [7:0] dataout;
  } exp_t;

  exp_t       sbq[$];
  vec_t       vecs[7];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the expected result of a request; the dataout model follows reads.
  task automatic push_exp(input vec_t v);
    exp_t e;
    if (!v.wr) model_dout = v.prdata;
    e.paddr   = v.addr;
    e.pwdata  = v.data;
    e.pwrite  = v.wr;
    e.dataout = model_dout;
    sbq.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [3:0] a,
                                    input logic [7:0] d, input logic w, input logic [7:0] dout);
    chk({tag, "_psel"},    32'(Psel), 0);
    chk({tag, "_penable"}, 32'(Penable), 0);
    chk({tag, "_pslverr"}, 32'(Pslverr), 0);
    chk({tag, "_paddr"},   32'(Paddr), 32'(a));
    chk({tag, "_pwdata"},  32'(PWdata), 32'(d));
    chk({tag, "_pwrite"},  32'(Pwrite), 32'(w));
    chk({tag, "_dataout"}, 32'(dataout), 32'(dout));
  endtask

  // Pop the oldest expected transfer and compare against the now-idle bus.
  task automatic complete_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_queue: got empty scoreboard expected an entry", tag);
    end else begin
      e = sbq.pop_front();
      check_idle_outputs(tag, e.paddr, e.pwdata, e.pwrite, e.dataout);
    end
  endtask

  // One transfer from IDLE; entered and left at a negedge.
  task automatic run_vec(input vec_t v);
    Addr = v.addr; datain = v.data; wr = v.wr; PRdata = v.prdata;
    newd = 1'b1; Pready = 1'b0;
    push_exp(v);
    @(posedge Pclk); @(negedge Pclk);
    // SETUP: scramble request inputs and raise Pready; both must be ignored.
    newd = 1'b0; Addr = ~v.addr; datain = ~v.data; wr = ~v.wr; Pready = 1'b1;
    chk("setup_psel",    32'(Psel), 1);
    chk("setup_penable", 32'(Penable), 0);
    chk("setup_paddr",   32'(Paddr), 32'(sbq[0].paddr));
    chk("setup_pwdata",  32'(PWdata), 32'(sbq[0].pwdata));
    chk("setup_pwrite",  32'(Pwrite), 32'(sbq[0].pwrite));
    @(posedge Pclk); @(negedge Pclk);
    for (int c = 0; c <= v.waits; c++) begin
      chk("access_penable", 32'(Penable), 1);
      chk("access_psel",    32'(Psel), 1);
      chk("access_paddr",   32'(Paddr), 32'(sbq[0].paddr));
      chk("access_pwdata",  32'(PWdata), 32'(sbq[0].pwdata));
      Pready = (c == v.waits);
      @(posedge Pclk); @(negedge Pclk);
    end
    Pready = 1'b0;
    complete_check("done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   k;

    vecs[0] = '{4'd4,  8'd12,  1'b1, 8'h00, 2};
    vecs[1] = '{4'd9,  8'd255, 1'b1, 8'h5A, 5};
    vecs[2] = '{4'd5,  8'h00,  1'b0, 8'd10, 0};
    vecs[3] = '{4'd3,  8'h81,  1'b0, 8'hA5, 2};
    vecs[4] = '{4'd15, 8'h3C,  1'b1, 8'h77, 1};
    vecs[5] = '{4'd0,  8'hFF,  1'b0, 8'h00, 3};
    vecs[6] = '{4'd2,  8'h11,  1'b0, 8'hC3, 0};

    // Reset held with Pready low; everything must read zero.
    repeat (5) @(posedge Pclk);
    @(negedge Pclk);
    check_idle_outputs("reset", 4'd0, 8'd0, 1'b0, 8'd0);
    Presetn = 1'b0;
    @(negedge Pclk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: newd high across completion of a write, then a read.
    v = '{4'd6, 8'h5A, 1'b1, 8'h00, 0};
    Addr = v.addr; datain = v.data; wr = v.wr; newd = 1'b1; Pready = 1'b0;
    push_exp(v);
    @(posedge Pclk); @(negedge Pclk);
    chk("b2b_setup1_paddr", 32'(Paddr), 6);
    @(posedge Pclk); @(negedge Pclk);
    chk("b2b_access1_penable", 32'(Penable), 1);
    v = '{4'hC, 8'h33, 1'b0, 8'h99, 0};
    Addr = v.addr; datain = v.data; wr = v.wr; PRdata = v.prdata; Pready = 1'b1;
    push_exp(v);
    @(posedge Pclk); @(negedge Pclk);
    e = sbq.pop_front();
    chk("b2b_first_dataout", 32'(dataout), 32'(e.dataout));
    chk("b2b_setup2_psel",    32'(Psel), 1);
    chk("b2b_setup2_penable", 32'(Penable), 0);
    chk("b2b_setup2_paddr",   32'(Paddr), 32'(sbq[0].paddr));
    chk("b2b_setup2_pwrite",  32'(Pwrite), 32'(sbq[0].pwrite));
    newd = 1'b0; Pready = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    chk("b2b_access2_penable", 32'(Penable), 1);
    chk("b2b_access2_psel",    32'(Psel), 1);
    Pready = 1'b1;
    @(posedge Pclk); @(negedge Pclk);
    Pready = 1'b0;
    complete_check("b2b_done");

    // Stalled slave: watchdog abort when enabled, indefinite wait otherwise.
    v = '{4'd7, 8'h00, 1'b0, 8'hEE, 0};
    Addr = v.addr; datain = v.data; wr = v.wr; PRdata = v.prdata; newd = 1'b1; Pready = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    newd = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    chk("stall_access_penable", 32'(Penable), 1);
`ifdef APB_MASTER_TIMEOUT_EN
    k = 0;
    while (k < 40 && Psel === 1'b1) begin
      @(posedge Pclk); @(negedge Pclk);
      k++;
    end
    chk("timeout_edges",   32'(k), 15);
    chk("timeout_pslverr", 32'(Pslverr), 1);
    chk("timeout_psel",    32'(Psel), 0);
    chk("timeout_penable", 32'(Penable), 0);
    chk("timeout_dataout", 32'(dataout), 32'(model_dout));
    @(posedge Pclk); @(negedge Pclk);
    chk("timeout_pslverr_pulse", 32'(Pslverr), 0);
    chk("timeout_idle_psel",     32'(Psel), 0);
`else
    push_exp(v);
    k = 0;
    repeat (20) begin
      @(posedge Pclk); @(negedge Pclk);
      if (Penable === 1'b1 && Pslverr === 1'b0) k++;
    end
    chk("stall_wait_cycles", 32'(k), 20);
    Pready = 1'b1;
    @(posedge Pclk); @(negedge Pclk);
    Pready = 1'b0;
    complete_check("stall_done");
`endif

    // Asynchronous reset in the middle of ACCESS.
    Addr = 4'hA; datain = 8'h42; wr = 1'b1; newd = 1'b1;
    @(posedge Pclk); @(negedge Pclk);
    newd = 1'b0;
    @(posedge Pclk); @(negedge Pclk);
    chk("midrst_access_penable", 32'(Penable), 1);
    #2 Presetn = 1'b1;
    #1;
    model_dout = '0;
    check_idle_outputs("midrst", 4'd0, 8'd0, 1'b0, 8'd0);
    @(negedge Pclk);
    Presetn = 1'b0;
    @(negedge Pclk);

    // Recovery after reset.
    run_vec('{4'd1, 8'h00, 1'b0, 8'h3C, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
